// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: permutation limits, IV and sequencer states.
package ascon_pkg;

  localparam int MAX_ROUNDS = 12;

  localparam logic [63:0] ASCON_IV = 64'h8040_0c06_0000_0000;

  localparam logic [3:0] OUT_DOUBLE_BYTES_DATA = 4'd4;
  localparam logic [3:0] OUT_DOUBLE_BYTES_TAG  = 4'd8;
  localparam logic [3:0] OUT_DOUBLE_BYTES_FULL = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4,
    S_WAIT  = 3'd5
  } seq_state_t;

  // Zero or oversize requests fall back to the full permutation.
  function automatic logic [3:0] clamp_rounds(
    input logic [3:0] n,
    input logic [3:0] max_n
  );
    return (n == 4'd0 || n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/ascon_rc_gen.sv
// Round index counter and Ascon round constant generator.
module ascon_rc_gen #(
  parameter int MAX_ROUNDS = ascon_pkg::MAX_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] idx,
  input  logic       en,
  output logic [3:0] r,
  output logic [7:0] round_const,
  output logic       last
);

  localparam logic [3:0] LAST_R = 4'(MAX_ROUNDS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= 4'd0;
    end else if (load) begin
      r <= idx;
    end else if (en) begin
      r <= r + 4'd1;
    end
  end

  assign round_const = {4'hF - r, r};
  assign last        = (r == LAST_R);

endmodule

// File: rtl/ascon_round_sequencer.sv
// Sequences key/nonce load, IV init, permutation rounds and handoff.
module ascon_round_sequencer #(
  parameter int MAX_ROUNDS = ascon_pkg::MAX_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  num_rounds,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        load_en,
  output logic [3:0]  load_sel,
  output logic [15:0] load_data,
  output logic        init_iv,
  output logic        round_en,
  output logic [7:0]  round_const,
  output logic        rounds_done,
  input  logic        out_ack,
  output logic        busy
);

  import ascon_pkg::*;

  localparam logic [3:0] MAX_N = 4'(MAX_ROUNDS);

  seq_state_t state;
  logic [3:0] n;
  logic [3:0] cnt;
  logic       rc_load;
  logic       rc_en;
  logic [3:0] rc_idx;
  logic [3:0] r;
  logic [7:0] rc;
  logic       rc_last;

  assign rc_load = (state == S_INIT);
  assign rc_en   = (state == S_ROUND);
  assign rc_idx  = MAX_N - n;

  ascon_rc_gen #(
    .MAX_ROUNDS(MAX_ROUNDS)
  ) u_rc_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (rc_load),
    .idx        (rc_idx),
    .en         (rc_en),
    .r          (r),
    .round_const(rc),
    .last       (rc_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      n           <= 4'd0;
      cnt         <= 4'd0;
      in_ready    <= 1'b0;
      load_en     <= 1'b0;
      load_sel    <= 4'd0;
      load_data   <= 16'd0;
      init_iv     <= 1'b0;
      round_en    <= 1'b0;
      round_const <= 8'd0;
      rounds_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      load_en     <= 1'b0;
      init_iv     <= 1'b0;
      round_en    <= 1'b0;
      round_const <= 8'd0;
      rounds_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n        <= clamp_rounds(num_rounds, MAX_N);
            cnt      <= 4'hF;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            load_en   <= 1'b1;
            load_sel  <= cnt;
            load_data <= in_data;
            cnt       <= cnt - 4'd1;
            if (cnt == 4'd0) begin
              in_ready <= 1'b0;
              state    <= S_INIT;
            end
          end
        end
        S_INIT: begin
          init_iv <= 1'b1;
          state   <= S_ROUND;
        end
        S_ROUND: begin
          round_en    <= 1'b1;
          round_const <= rc;
          if (rc_last) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          rounds_done <= 1'b1;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // A start arriving with the ack is dropped, not queued.
          if (out_ack) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic unused_r;
  assign unused_r = ^r;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Self-checking bench: timestamp-based model plus literal pins.
module tb_ascon_round_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_rounds;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        load_en;
  logic [3:0]  load_sel;
  logic [15:0] load_data;
  logic        init_iv;
  logic        round_en;
  logic [7:0]  round_const;
  logic        rounds_done;
  logic        out_ack;
  logic        busy;

  ascon_round_sequencer #(.MAX_ROUNDS(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rounds (num_rounds),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_en    (load_en),
    .load_sel   (load_sel),
    .load_data  (load_data),
    .init_iv    (init_iv),
    .round_en   (round_en),
    .round_const(round_const),
    .rounds_done(rounds_done),
    .out_ack    (out_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Model: an operation is described by its start, its handshake count
  // and the edge of its 16th handshake; all outputs follow from those.
  int   cyc = 0;
  bit   m_ok = 0;
  bit   m_active = 0;
  bit   m_irdy = 0;
  bit   m_fresh = 0;
  int   m_n = 0;
  int   m_nhs = 0;
  int   m_tlast = 0;
  logic       e_load, e_init, e_round, e_done, e_busy;
  logic [3:0] e_sel;
  logic [15:0] e_data;
  logic [7:0] e_rc;

  function automatic int clamp_n(input logic [3:0] v);
    return (v == 0 || v > 12) ? 12 : int'(v);
  endfunction

  always @(posedge clk) begin
    int rr;
    cyc++;
    e_load = 0; e_init = 0; e_round = 0; e_rc = 0; e_done = 0;
    if (rst) begin
      m_ok = 1; m_active = 0; m_nhs = 0; m_fresh = 1;
      e_sel = 0; e_data = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_n = clamp_n(num_rounds);
        m_nhs = 0; m_tlast = -1000;
      end
    end else begin
      if (m_irdy && in_valid) begin
        e_load = 1; e_sel = 4'(15 - m_nhs); e_data = in_data;
        m_fresh = 0; m_nhs++;
        if (m_nhs == 16) m_tlast = cyc;
      end
      if (m_nhs == 16) begin
        if (cyc == m_tlast + 1) e_init = 1;
        if (cyc >= m_tlast + 2 && cyc <= m_tlast + 1 + m_n) begin
          e_round = 1;
          rr = 12 - m_n + (cyc - m_tlast - 2);
          e_rc = {4'(15 - rr), 4'(rr)};
        end
        if (cyc == m_tlast + 2 + m_n) e_done = 1;
        if (cyc >= m_tlast + 3 + m_n && out_ack) m_active = 0;
      end
    end
    m_irdy = m_active && m_nhs < 16;
    e_busy = m_active;
  end

  // Observations for the literal pins.
  logic [7:0] q_rc[$];
  int n_ld, n_init, n_done;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready", in_ready, m_irdy);
      chk("busy", busy, e_busy);
      chk("load_en", load_en, e_load);
      chk("init_iv", init_iv, e_init);
      chk("round_en", round_en, e_round);
      chk("round_const", round_const, e_rc);
      chk("rounds_done", rounds_done, e_done);
      chk("excl", 32'($countones({load_en, init_iv, round_en, rounds_done}) <= 1), 1);
      if (e_load || m_fresh) begin
        chk("load_sel", load_sel, e_sel);
        chk("load_data", load_data, e_data);
      end
      if (round_en) q_rc.push_back(round_const);
      if (load_en) n_ld++;
      if (init_iv) n_init++;
      if (rounds_done) n_done++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_obs();
    q_rc.delete();
    n_ld = 0; n_init = 0; n_done = 0;
  endtask

  task automatic do_start(input logic [3:0] n);
    clear_obs();
    start = 1; num_rounds = n;
    tick();
    start = 0; num_rounds = 0;
  endtask

  task automatic load_until(input int target, input bit stall, input bit noise);
    int g = 0;
    while (m_nhs < target && m_active && g < 200) begin
      in_valid = stall ? (g % 3 == 0) : 1'b1;
      in_data = 16'($urandom);
      start = noise;
      g++;
      tick();
    end
    in_valid = 0; start = 0;
    if (m_nhs < target) fail_now("load_wait");
  endtask

  task automatic run_op(input logic [3:0] n, input bit stall, input bit noise);
    int g = 0;
    do_start(n);
    load_until(16, stall, noise);
    while (m_active && g < 100) begin
      out_ack = noise ? 1'b1 : (cyc >= m_tlast + 4 + m_n);
      start = noise;
      g++;
      tick();
    end
    out_ack = 0; start = 0;
    if (m_active) fail_now("ack_wait");
    tick();
  endtask

  initial begin
    int g;
    rst = 1; start = 0; num_rounds = 0;
    in_valid = 0; in_data = 0; out_ack = 0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_round_const", round_const, 0);
    rst = 0;
    tick();
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_load_sel", load_sel, 0);

    run_op(4'd12, 0, 0);
    chk("full_loads", n_ld, 16);
    chk("full_init", n_init, 1);
    chk("full_done", n_done, 1);
    chk("full_rounds", q_rc.size(), 12);
    if (q_rc.size() == 12) begin
      chk("full_rc0", q_rc[0], 8'hF0);
      chk("full_rc1", q_rc[1], 8'hE1);
      chk("full_rc11", q_rc[11], 8'h4B);
    end

    run_op(4'd6, 0, 0);
    chk("n6_rounds", q_rc.size(), 6);
    if (q_rc.size() == 6) begin
      chk("n6_rc0", q_rc[0], 8'h96);
      chk("n6_rc5", q_rc[5], 8'h4B);
    end

    run_op(4'd8, 0, 0);
    chk("n8_rounds", q_rc.size(), 8);
    if (q_rc.size() > 0) chk("n8_rc0", q_rc[0], 8'hB4);

    run_op(4'd0, 0, 0);
    chk("n0_rounds", q_rc.size(), 12);
    run_op(4'd13, 0, 0);
    chk("n13_rounds", q_rc.size(), 12);

    run_op(4'd12, 1, 0);
    chk("stall_loads", n_ld, 16);
    chk("stall_init", n_init, 1);

    run_op(4'd12, 0, 1);
    chk("noise_rounds", q_rc.size(), 12);
    chk("noise_busy", busy, 0);

    // Reset during LOAD with the load counter at 7.
    do_start(4'd12);
    load_until(8, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_load_busy", busy, 0);
    chk("rst_load_in_ready", in_ready, 0);
    tick();
    run_op(4'd12, 0, 0);
    chk("after_rst_loads", n_ld, 16);
    chk("after_rst_rounds", q_rc.size(), 12);

    // Reset during ROUND at r=5.
    do_start(4'd12);
    load_until(16, 0, 0);
    g = 0;
    while (cyc < m_tlast + 6 && g < 50) begin g++; tick(); end
    if (cyc < m_tlast + 6) fail_now("round_wait");
    rst = 1;
    tick();
    rst = 0;
    chk("rst_round_en", round_en, 0);
    chk("rst_round_busy", busy, 0);
    tick();
    run_op(4'd7, 0, 0);
    chk("n7_rounds", q_rc.size(), 7);
    if (q_rc.size() > 0) chk("n7_rc0", q_rc[0], 8'hA5);
    chk("n7_loads", n_ld, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_round_sequencer.md
ASCON_ROUND_SEQUENCER -- requirements
Module: ascon_round_sequencer

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 12, meaning the full permutation round count p^a.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one operation; sampled only in IDLE.
- num_rounds  in  4  rounds to run, latched at start.
- in_valid  in  1  key/nonce double-byte valid.
- in_data  in  16  key/nonce double-byte.
- in_ready  out  1  sequencer accepts in_data.
- load_en  out  1  write load_data into state slice load_sel.
- load_sel  out  4  double-byte index 15..0 (15 = S_1[63:48], 0 = S_4[15:0]).
- load_data  out  16  registered copy of accepted in_data.
- init_iv  out  1  one-cycle pulse: write IV into S_0.
- round_en  out  1  permutation performs one round this cycle.
- round_const  out  8  round constant for the current round.
- rounds_done  out  1  one-cycle pulse after the last round; drives the output controller's advance.
- out_ack  in  1  downstream has finished reading the state.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 SHALL implement the FSM IDLE -> LOAD -> INIT -> ROUND -> DONE -> WAIT -> IDLE.
REQ-004 In IDLE, start=1 SHALL latch num_rounds into N, set the load counter to 15, and enter LOAD on the next cycle.
REQ-005 N SHALL be clamped: a value of 0 or a value above MAX_ROUNDS SHALL be replaced by MAX_ROUNDS.
REQ-006 In LOAD, in_ready SHALL be 1, and each in_valid&in_ready handshake SHALL be handled as follows:
- load_en=1, load_sel=counter and load_data=in_data SHALL be registered and appear the following cycle.
- The counter SHALL then decrement.
REQ-007 The handshake at counter 0 SHALL cause the transition to INIT; exactly 16 handshakes are required, and in_valid=0 cycles SHALL stall without limit.
REQ-008 INIT SHALL last one cycle with init_iv=1, then enter ROUND with the round index r = MAX_ROUNDS - N.
REQ-009 In ROUND, each cycle SHALL assert round_en=1 with round_const = {(15-r)[3:0], r[3:0]}, then increment r.
REQ-010 The cycle with r = MAX_ROUNDS-1 SHALL be the last ROUND cycle, so ROUND lasts exactly N cycles.
REQ-011 DONE SHALL last one cycle with rounds_done=1, then enter WAIT.
REQ-012 In WAIT, out_ack=1 SHALL return the FSM to IDLE on the next cycle; out_ack SHALL be ignored in all other states.
REQ-013 start SHALL be ignored whenever busy=1; start and out_ack in the same WAIT cycle SHALL go to IDLE only, with no new operation.
REQ-014 load_en, init_iv, round_en and rounds_done SHALL be mutually exclusive.
REQ-015 round_const SHALL be 0x00 whenever round_en=0.
REQ-016 Latency SHALL be:
- start to first in_ready: 1 cycle.
- last load handshake to init_iv: 1 cycle.
- init_iv to first round_en: 1 cycle.
- last round_en to rounds_done: 1 cycle.

Reset
REQ-017 rst=1 at a clock edge SHALL force IDLE from any state, including mid-LOAD and mid-ROUND.
REQ-018 While reset is applied, and on the cycle after it, every output SHALL be 0: in_ready, load_en, load_sel, load_data, init_iv, round_en, round_const, rounds_done and busy.
REQ-019 Reset SHALL clear N, r and the load counter; a partial load SHALL NOT resume after reset.

Structure
REQ-020 FSM state encodings, MAX_ROUNDS and the 64-bit Ascon IV constant SHALL live in the shared package ascon_pkg, alongside the existing OUT_DOUBLE_BYTES_* encodings.
REQ-021 The round counter and constant generation SHALL be a sub-module ascon_rc_gen with:
- inputs: clk, rst, start-index load, enable.
- outputs: r, round_const, last.
REQ-022 No storage of the 320-bit state SHALL exist in this block.

Verification
REQ-023 Full run: start with num_rounds=12, then 16 back-to-back handshakes. Required response:
- load_sel runs 15..0 with load_data matching in_data.
- One init_iv pulse.
- 12 round_en cycles with constants 0xF0, 0xE1, ... 0x4B.
- One rounds_done; busy stays 1 until out_ack.
REQ-024 Reduced and clamped rounds:
- num_rounds=6 -> constants 0x96..0x4B over 6 cycles.
- num_rounds=8 -> constants start at 0xB4.
- num_rounds=0 and num_rounds=13 -> 12 rounds each.
REQ-025 Stalled load: in_valid toggled 1,0,0,1,... -> exactly 16 load_en pulses with indices unchanged; INIT is entered only after the 16th handshake.
REQ-026 Reset mid-operation: rst asserted during LOAD at counter 7 and during ROUND at r=5 -> all outputs 0 the next cycle; a fresh start performs a complete 16-load, N-round sequence.
REQ-027 Ignored inputs: start pulsed in LOAD, ROUND, DONE and WAIT, and out_ack pulsed in ROUND -> no state change; start plus out_ack together in WAIT -> IDLE with busy=0.
